// File: rtl/max_stream.sv
// -----------------------------------------------------------------------------
// max_stream
//   Streaming frame-maximum reducer. Unsigned samples arrive on a valid/ready
//   input stream. They are grouped into frames of FRAME_LEN samples. The
//   largest value of each completed frame is then offered on a valid/ready
//   output stream, together with its 0-based position if that is enabled.
//
//   Optional feature macro: MAX_STREAM_ARGMAX_EN
//     defined   : the run_idx tracker is built and out_idx reports the position
//                 of the maximum. Ties resolve to the earliest sample.
//     undefined : the run_idx tracker is omitted and out_idx is tied to 0.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   in_data holds a sample
//   in_ready   out  a sample can be accepted this cycle (state ACC only)
//   in_data    in   [WIDTH-1:0] unsigned sample
//   out_valid  out  a frame result is presented (state OUT only)
//   out_ready  in   the consumer takes the result this cycle
//   out_max    out  [WIDTH-1:0] maximum of the completed frame
//   out_idx    out  [IDX_W-1:0] position of that maximum within the frame
// -----------------------------------------------------------------------------
module max_stream #(
  parameter  int WIDTH     = 8,
  parameter  int FRAME_LEN = 4,
  localparam int IDX_W     = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [IDX_W-1:0] out_idx
);

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_e;

  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(FRAME_LEN - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] run_max_q, run_max_d;

  logic accept;
  logic first;
  logic take;

  assign accept = in_valid && (state_q == ACC);
  assign first  = (cnt_q == '0);
  // The first sample of a frame always loads, so no stale maximum survives
  // from the previous frame. After that, only a strictly larger sample
  // replaces the current maximum, which keeps the earliest position on ties.
  assign take   = accept && (first || (in_data > run_max_q));

  // ---------------------------------------------------------------------------
  // FSM next state and handshake outputs.
  // in_ready depends only on the state, so there is no path from out_ready.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    run_max_d = run_max_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACC: begin
        in_ready = 1'b1;
        if (take) run_max_d = in_data;
        if (accept) begin
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = OUT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACC;
      cnt_q     <= '0;
      run_max_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      run_max_q <= run_max_d;
    end
  end

  // The result registers are only written while in ACC, so they hold
  // steady for the whole time OUT waits for out_ready.
  assign out_max = run_max_q;

`ifdef MAX_STREAM_ARGMAX_EN
  logic [IDX_W-1:0] run_idx_q, run_idx_d;

  always_comb begin
    run_idx_d = run_idx_q;
    if (take) run_idx_d = first ? '0 : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_idx_q <= '0;
    else        run_idx_q <= run_idx_d;
  end

  assign out_idx = run_idx_q;
`else
  assign out_idx = '0;
`endif

endmodule

// File: tb/tb_max_stream.sv
// -----------------------------------------------------------------------------
// tb_max_stream
//   Scoreboard bench for max_stream (WIDTH=8, FRAME_LEN=4). The stimulus drives
//   directed and random frames. A monitor on the falling edge observes accepted
//   samples and builds frames in a queue. For each completed frame it computes
//   the expected maximum and first position, and pops that result when the DUT
//   hands a result over.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_max_stream;
  localparam int W  = 8;
  localparam int FL = 4;
  localparam int IW = $clog2(FL);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_max;
  logic [IW-1:0] out_idx;

  max_stream #(.WIDTH(W), .FRAME_LEN(FL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_idx   (out_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard -----------------------------
  logic [W-1:0]  frame[$];
  logic [W-1:0]  exp_max[$];
  logic [IW-1:0] exp_idx[$];
  logic          last_acc = 1'b0;
  logic          held     = 1'b0;
  logic [W-1:0]  h_max;
  logic [IW-1:0] h_idx;

  task automatic model_frame();
    int mx;
    int ix;
    mx = -1;
    ix = 0;
    foreach (frame[i]) if (int'(frame[i]) > mx) mx = int'(frame[i]);
    for (int i = FL - 1; i >= 0; i--) if (int'(frame[i]) == mx) ix = i;
`ifndef MAX_STREAM_ARGMAX_EN
    ix = 0;
`endif
    exp_max.push_back(W'(mx));
    exp_idx.push_back(IW'(ix));
    frame.delete();
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      frame.delete();
      exp_max.delete();
      exp_idx.delete();
      last_acc = 1'b0;
      held     = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_max",   32'(out_max),   32'd0);
      chk("rst_out_idx",   32'(out_idx),   32'd0);
    end else begin
      chk("in_ready_vs_out_valid", 32'(in_ready), 32'(!out_valid));
      if (last_acc) chk("latency_out_valid", 32'(out_valid), 32'd1);
      if (held) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_max",   32'(out_max),   32'(h_max));
        chk("hold_idx",   32'(out_idx),   32'(h_idx));
      end
      last_acc = 1'b0;
      if (out_valid) begin
        chk("result_expected", 32'(exp_max.size() > 0), 32'd1);
        if (out_ready && exp_max.size() > 0) begin
          chk("out_max", 32'(out_max), 32'(exp_max.pop_front()));
          chk("out_idx", 32'(out_idx), 32'(exp_idx.pop_front()));
        end
      end
      held  = out_valid && !out_ready;
      h_max = out_max;
      h_idx = out_idx;
      if (in_valid && in_ready) begin
        frame.push_back(in_data);
        if (frame.size() == FL) begin
          model_frame();
          last_acc = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus --------------------------------------------------
  logic rnd_ready = 1'b0;

  always @(posedge clk) begin
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [W-1:0] d);
    logic a;
    int   n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    do begin
      @(negedge clk);
      a = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!a && n < 200);
    if (!a) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    in_data  = W'($urandom);
  endtask

  task automatic gap(input int n);
    in_valid = 1'b0;
    in_data  = W'($urandom);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send4(input logic [W-1:0] a, b, c, d, input int gmax);
    send(a); gap($urandom_range(0, gmax));
    send(b); gap($urandom_range(0, gmax));
    send(c); gap($urandom_range(0, gmax));
    send(d); gap($urandom_range(0, gmax));
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    gap(1);

    // Back-to-back samples, then ties, an all-0xFF frame, and a zero frame after a large one.
    send4(8'd3,   8'd9,   8'd2,   8'd7,   0);
    send4(8'd5,   8'd5,   8'd1,   8'd5,   0);
    send4(8'hFF,  8'hFF,  8'hFF,  8'hFF,  0);
    send4(8'd200, 8'd1,   8'd1,   8'd1,   0);
    send4(8'd0,   8'd0,   8'd0,   8'd0,   0);
    gap(2);

    // Backpressure: hold the result for 5 cycles, then the next frame.
    out_ready = 1'b0;
    send4(8'd1, 8'd2, 8'd3, 8'd4, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("stall_out_valid_seen", 32'(out_valid), 32'd1);
    gap(5);
    out_ready = 1'b1;
    send4(8'd8, 8'd6, 8'd4, 8'd2, 0);
    gap(2);

    // Reset in the middle of a frame discards the partial frame.
    send(8'd50);
    send(8'd60);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    send4(8'd10, 8'd20, 8'd30, 8'd40, 0);
    gap(2);

    // Random frames with input gaps and random backpressure.
    send4(8'd3, 8'd9, 8'd2, 8'd7, 3);
    rnd_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      for (int s = 0; s < FL; s++) begin
        if (f % 3 == 0) send(W'($urandom_range(0, 3)));
        else            send(W'($urandom));
        gap($urandom_range(0, 2));
      end
    end

    // Drain the remaining results.
    #2;
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_max.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", 32'(exp_max.size()), 32'd0);
    chk("final_frame_empty", 32'(frame.size()), 32'd0);
    gap(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/max_stream.md
# max_stream

Streaming frame-maximum reducer. Consumes unsigned samples over a valid/ready input stream, groups them into fixed-length frames of `FRAME_LEN` samples, and presents the largest value of each completed frame (and, optionally, its position) on a valid/ready output stream. It is the sequential, max-seeking companion to the combinational 4-input minimum selector. It sits between a sample producer and any consumer that needs per-frame peaks.

## Interface

Parameters:
- `WIDTH`, 8: sample and result width, in bits, unsigned.
- `FRAME_LEN`, 4: samples per frame; legal range 2..256.
- `IDX_W`, `$clog2(FRAME_LEN)`: width of the index and sample counter; derived, never overridden.

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst_n`, input, 1: reset, asynchronous assert, active-low.
- `in_valid`, input, 1: `in_data` holds a sample.
- `in_ready`, output, 1: block can accept a sample this cycle.
- `in_data`, input, `WIDTH`: sample value, unsigned.
- `out_valid`, output, 1: `out_max` and `out_idx` hold a completed frame result.
- `out_ready`, input, 1: consumer accepts the result this cycle.
- `out_max`, output, `WIDTH`: maximum of the completed frame.
- `out_idx`, output, `IDX_W`: 0-based position of the maximum within the frame (see Configuration).

## Operation

- Two-state FSM:
  - `ACC` is the reset state. `in_ready=1`, `out_valid=0`.
  - `OUT`: `in_ready=0`, `out_valid=1`.
- Accept: `in_valid && in_ready` at a rising edge. Samples are not sampled when not accepted, and `in_data` is ignored when `in_valid=0`.
- Registers: `cnt` (`IDX_W` bits), `run_max` (`WIDTH`), `run_idx` (`IDX_W`).
- On accept in `ACC`:
  - If `cnt==0`, load `run_max=in_data` and `run_idx=0` unconditionally.
  - Otherwise, if `in_data > run_max` (unsigned, strict), load `run_max=in_data` and `run_idx=cnt`.
  - Ties keep the earliest position.
  - If `cnt==FRAME_LEN-1`, go to `OUT` and set `cnt=0`. Otherwise set `cnt=cnt+1`.
- `out_max` and `out_idx` are driven directly from `run_max` and `run_idx`. They stay stable for as long as `out_valid=1`.
- In `OUT`, when `out_ready=1`, the result is consumed and the FSM returns to `ACC`.
- Gaps on `in_valid` only stall the frame; partial frames persist indefinitely.
- No early frame termination and no overflow: the counter range is bounded by `FRAME_LEN`.

## Timing

- Reset values:
  - `in_ready=1` once `rst_n` is high (state `ACC`).
  - `out_valid=0`, `out_max=0`, `out_idx=0`.
  - `cnt=0`, `run_max=0`, `run_idx=0`.
- Reset mid-frame or while in `OUT` discards the partial frame or pending result immediately (asynchronously). No result is emitted.
- Latency: `out_valid` rises in the cycle after the edge that accepts the last sample of the frame.
- Throughput: at best `FRAME_LEN` samples per `FRAME_LEN+1` cycles. There is one mandatory `in_ready=0` cycle per frame, the cycle where `OUT` is handshaked.
- `in_ready` depends only on state. It has no combinational path from `out_ready`.
- `out_valid` never drops without a handshake. While `out_ready=0`, `in_ready` stays 0 (backpressure).

## Configuration

- Macro: `MAX_STREAM_ARGMAX_EN`.
- Defined: `run_idx` is implemented and `out_idx` reports the position of the maximum as described above.
- Undefined: `run_idx` logic is omitted. The `out_idx` port is still present and tied to 0. `out_max` and all timing are unchanged.

## Test plan

All scenarios use `FRAME_LEN=4`, `WIDTH=8`, `MAX_STREAM_ARGMAX_EN` defined unless noted.

- Back-to-back samples 3, 9, 2, 7 with `out_ready=1`:
  - `out_valid=1` for one cycle, one cycle after the 4th accept, with `out_max=9`, `out_idx=1`.
  - `in_ready=0` in that cycle only.
- Ties 5, 5, 1, 5 then all-0xFF frame:
  - First frame gives `out_max=5`, `out_idx=0`.
  - Second frame gives `out_max=255`, `out_idx=0`.
- Frame 0, 0, 0, 0 after a frame of 200, 1, 1, 1:
  - Results are `out_max=0`, `out_idx=0`, with no stale value from the previous frame.
  - Confirms the `cnt==0` reload.
- Frame 1, 2, 3, 4 with `out_ready=0` for 5 cycles after `out_valid` rises:
  - `out_max=4` and `out_idx=3` stay stable throughout.
  - `in_ready` stays 0 throughout.
  - After the handshake, the next frame 8, 6, 4, 2 yields `out_max=8`, `out_idx=0`.
- Accept 50, 60, then pulse `rst_n` low for one cycle:
  - `out_valid` stays 0.
  - The following frame 10, 20, 30, 40 yields `out_max=40`, `out_idx=3` after exactly 4 accepts.
- Macro undefined, frame 3, 9, 2, 7 with random `in_valid` gaps: `out_max=9` and `out_idx=0`.
